// File: rtl/drac_if_stage.sv
// drac_if_stage: instruction-fetch stage of the DRAC in-order pipeline.
// Owns the fetch PC, issues one I-cache request per cycle and forwards the
// response to decode with any fetch exception attached.
// Optional feature: define IF_BRANCH_PRED_EN to build the 16-entry
// direct-mapped branch predictor; otherwise fall-through is always pc+4.

package drac_pkg;
   typedef logic [39:0] addr_t;
   typedef logic [39:0] addrPC_t;

   typedef enum logic [1:0] {
      NEXT_PC_SEL_KEEP_PC    = 2'd0,
      NEXT_PC_SEL_JUMP       = 2'd1,
      NEXT_PC_SEL_BP_OR_PC_4 = 2'd2
   } next_pc_sel_t;

   typedef struct packed {
      next_pc_sel_t next_pc;
   } cu_if_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic        instr_access_fault;
      logic        instr_page_fault;
   } resp_icache_cpu_t;

   typedef struct packed {
      addrPC_t pc_execution;
      addrPC_t branch_addr_result;
      logic    branch_taken;
      logic    is_branch_exe;
   } exe_if_branch_pred_t;

   typedef struct packed {
      logic  valid;
      addr_t vaddr;
      logic  invalidate_icache;
      logic  invalidate_buffer;
   } req_cpu_icache_t;

   typedef struct packed {
      logic    decision;
      addrPC_t pred_addr;
   } bpred_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] cause;
      logic [63:0] origin;
   } exception_t;

   typedef struct packed {
      addrPC_t     pc_inst;
      logic [31:0] inst;
      logic        valid;
      bpred_t      bpred;
      exception_t  ex;
   } if_id_stage_t;
endpackage

module drac_if_stage
   import drac_pkg::*;
(
   input  logic                clk_i,
   input  logic                rstn_i,
   input  addr_t               reset_addr_i,
   input  logic                stall_i,
   input  cu_if_t              cu_if_i,
   input  logic                invalidate_icache_i,
   input  logic                invalidate_buffer_i,
   input  addrPC_t             pc_jump_i,
   input  resp_icache_cpu_t    resp_icache_cpu_i,
   input  exe_if_branch_pred_t exe_if_branch_pred_i,
   input  logic                retry_fetch_i,
   output req_cpu_icache_t     req_cpu_icache_o,
   output if_id_stage_t        fetch_o
);

   addrPC_t pc;
   addrPC_t pc_next;
   logic    misaligned;
   logic    pred_taken;
   addrPC_t pred_target;

`ifdef IF_BRANCH_PRED_EN
   logic [15:0] bp_valid;
   logic [33:0] bp_tag    [16];
   addrPC_t     bp_target [16];
   logic [1:0]  bp_cnt    [16];
   logic [3:0]  upd_idx;
   logic [3:0]  look_idx;
   logic        look_hit;
   logic [1:0]  unused_exe_low;

   assign upd_idx        = exe_if_branch_pred_i.pc_execution[5:2];
   assign look_idx       = pc[5:2];
   assign unused_exe_low = exe_if_branch_pred_i.pc_execution[1:0];

   // Predictor tables: written by execute's branch resolution, counters saturate.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         bp_valid <= '0;
         for (int unsigned i = 0; i < 16; i++) begin
            bp_cnt[i] <= 2'b01;
         end
      end else if (exe_if_branch_pred_i.is_branch_exe) begin
         bp_valid[upd_idx]  <= 1'b1;
         bp_tag[upd_idx]    <= exe_if_branch_pred_i.pc_execution[39:6];
         bp_target[upd_idx] <= exe_if_branch_pred_i.branch_addr_result;
         if (exe_if_branch_pred_i.branch_taken) begin
            if (bp_cnt[upd_idx] != 2'b11) bp_cnt[upd_idx] <= bp_cnt[upd_idx] + 2'd1;
         end else begin
            if (bp_cnt[upd_idx] != 2'b00) bp_cnt[upd_idx] <= bp_cnt[upd_idx] - 2'd1;
         end
      end
   end

   // Lookup reads the registered tables, so a same-cycle update is not visible.
   always_comb begin
      look_hit    = bp_valid[look_idx] && (bp_tag[look_idx] == pc[39:6]);
      pred_taken  = look_hit && bp_cnt[look_idx][1];
      pred_target = pred_taken ? bp_target[look_idx] : '0;
   end
`else
   logic unused_exe;
   assign unused_exe  = ^exe_if_branch_pred_i;
   assign pred_taken  = 1'b0;
   assign pred_target = '0;
`endif

   assign misaligned = (pc[1:0] != 2'b00);

   // Next-PC selection: jump beats stall/retry/keep, which beat fall-through.
   always_comb begin
      pc_next = pc;
      if (cu_if_i.next_pc == NEXT_PC_SEL_JUMP) begin
         pc_next = pc_jump_i;
      end else if (stall_i || retry_fetch_i || cu_if_i.next_pc == NEXT_PC_SEL_KEEP_PC) begin
         pc_next = pc;
      end else if (pred_taken) begin
         pc_next = pred_target;
      end else begin
         pc_next = pc + 40'd4;
      end
   end

   // Fetch PC register; reset loads the boot address and drops any redirect.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) pc <= reset_addr_i;
      else         pc <= pc_next;
   end

   // I-cache request and decode packet, both combinational from the current PC.
   always_comb begin
      req_cpu_icache_o.valid             = rstn_i && !misaligned;
      req_cpu_icache_o.vaddr             = pc;
      req_cpu_icache_o.invalidate_icache = invalidate_icache_i;
      req_cpu_icache_o.invalidate_buffer = invalidate_buffer_i;

      fetch_o                    = '0;
      fetch_o.pc_inst            = pc;
      fetch_o.inst               = misaligned ? 32'd0 : resp_icache_cpu_i.data;
      fetch_o.valid              = rstn_i && !stall_i && (resp_icache_cpu_i.valid || misaligned);
      fetch_o.bpred.decision     = pred_taken;
      fetch_o.bpred.pred_addr    = pred_target;

      if (rstn_i) begin
         if (misaligned) begin
            fetch_o.ex.valid  = 1'b1;
            fetch_o.ex.cause  = 64'h00;
            fetch_o.ex.origin = {24'd0, pc};
         end else if (resp_icache_cpu_i.instr_access_fault) begin
            fetch_o.ex.valid  = 1'b1;
            fetch_o.ex.cause  = 64'h01;
            fetch_o.ex.origin = {24'd0, pc};
         end else if (resp_icache_cpu_i.instr_page_fault) begin
            fetch_o.ex.valid  = 1'b1;
            fetch_o.ex.cause  = 64'h0C;
            fetch_o.ex.origin = {24'd0, pc};
         end
      end
   end

endmodule

// File: tb/tb_drac_if_stage.sv
// Testbench for drac_if_stage (default build, predictor disabled).
module tb_drac_if_stage;
   import drac_pkg::*;

   logic                clk = 1'b0;
   logic                rstn;
   addr_t               reset_addr;
   logic                stall;
   cu_if_t              cu;
   logic                inv_ic;
   logic                inv_buf;
   addrPC_t             pc_jump;
   resp_icache_cpu_t    resp;
   exe_if_branch_pred_t exe;
   logic                retry;
   req_cpu_icache_t     req;
   if_id_stage_t        fetch;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   logic [39:0] m_pc;
   bit          m_known = 1'b0;
   localparam logic [39:0] BASE = 40'h0080000000;

   always #5 clk = ~clk;

   drac_if_stage dut (
      .clk_i                (clk),
      .rstn_i               (rstn),
      .reset_addr_i         (reset_addr),
      .stall_i              (stall),
      .cu_if_i              (cu),
      .invalidate_icache_i  (inv_ic),
      .invalidate_buffer_i  (inv_buf),
      .pc_jump_i            (pc_jump),
      .resp_icache_cpu_i    (resp),
      .exe_if_branch_pred_i (exe),
      .retry_fetch_i        (retry),
      .req_cpu_icache_o     (req),
      .fetch_o              (fetch)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic idle();
      rstn = 1'b1; stall = 1'b0; retry = 1'b0; inv_ic = 1'b0; inv_buf = 1'b0;
      cu.next_pc = NEXT_PC_SEL_BP_OR_PC_4;
      resp = '0; exe = '0;
   endtask

   // Check every output against the model, then advance one clock.
   task automatic step();
      logic        mis;
      logic [63:0] cause;
      logic        exv;
      #2;
      if (m_known) begin
         mis   = (m_pc % 4) != 0;
         exv   = rstn && (mis || resp.instr_access_fault || resp.instr_page_fault);
         cause = mis ? 64'h0 : resp.instr_access_fault ? 64'h1 :
                 resp.instr_page_fault ? 64'hC : 64'h0;
         if (!exv) cause = 64'h0;
         chk("req_vaddr", 64'(req.vaddr), 64'(m_pc));
         chk("req_valid", 64'(req.valid), 64'(rstn && !mis));
         chk("req_inv_ic", 64'(req.invalidate_icache), 64'(inv_ic));
         chk("req_inv_buf", 64'(req.invalidate_buffer), 64'(inv_buf));
         chk("pc_inst", 64'(fetch.pc_inst), 64'(m_pc));
         chk("inst", 64'(fetch.inst), mis ? 64'h0 : 64'(resp.data));
         chk("fetch_valid", 64'(fetch.valid), 64'(rstn && !stall && (resp.valid || mis)));
         chk("ex_valid", 64'(fetch.ex.valid), 64'(exv));
         chk("ex_cause", fetch.ex.cause, cause);
         chk("ex_origin", fetch.ex.origin, exv ? 64'(m_pc) : 64'h0);
         chk("bp_decision", 64'(fetch.bpred.decision), 64'h0);
         chk("bp_addr", 64'(fetch.bpred.pred_addr), 64'h0);
      end
      @(posedge clk);
      if (!rstn) begin
         m_pc = reset_addr; m_known = 1'b1;
      end else if (cu.next_pc == NEXT_PC_SEL_JUMP) begin
         m_pc = pc_jump;
      end else if (!(stall || retry || cu.next_pc == NEXT_PC_SEL_KEEP_PC)) begin
         m_pc = (m_pc + 40'd4) % (41'd1 << 40);
      end
      #1;
   endtask

   initial begin
      idle();
      pc_jump = '0;
      reset_addr = BASE;
      rstn = 1'b0;
      step(); step();
      chk("reset_vaddr", 64'(req.vaddr), 64'(BASE));
      chk("reset_req_valid", 64'(req.valid), 64'h0);
      rstn = 1'b1;
      #2;
      chk("release_req_valid", 64'(req.valid), 64'h1);
      step();
      repeat (5) step();
      chk("seq_vaddr", 64'(req.vaddr), 64'(BASE + 40'h18));

      cu.next_pc = NEXT_PC_SEL_JUMP; pc_jump = BASE + 40'h8; step();
      cu.next_pc = NEXT_PC_SEL_KEEP_PC; stall = 1'b1;
      repeat (3) step();
      chk("stall_vaddr", 64'(req.vaddr), 64'(BASE + 40'h8));
      chk("stall_fetch_valid", 64'(fetch.valid), 64'h0);
      cu.next_pc = NEXT_PC_SEL_JUMP; pc_jump = 40'h1111111110; step();
      stall = 1'b0; cu.next_pc = NEXT_PC_SEL_BP_OR_PC_4;
      chk("jump_vaddr", 64'(req.vaddr), 64'h1111111110);
      chk("jump_req_valid", 64'(req.valid), 64'h1);

      inv_ic = 1'b1; step(); inv_ic = 1'b0;
      inv_buf = 1'b1; step(); inv_buf = 1'b0;

      cu.next_pc = NEXT_PC_SEL_JUMP; pc_jump = BASE + 40'h8; step();
      cu.next_pc = NEXT_PC_SEL_KEEP_PC;
      resp.valid = 1'b1; resp.data = 32'h12345678; step();
      resp.instr_access_fault = 1'b1; step();
      resp.instr_access_fault = 1'b0; resp.instr_page_fault = 1'b1; step();
      resp = '0;
      cu.next_pc = NEXT_PC_SEL_JUMP; pc_jump = 40'h3FF; step();
      cu.next_pc = NEXT_PC_SEL_KEEP_PC; step();
      chk("mis_vaddr", 64'(req.vaddr), 64'h3FF);
      chk("mis_ex_cause", fetch.ex.cause, 64'h0);
      chk("mis_ex_valid", 64'(fetch.ex.valid), 64'h1);

      for (int i = 0; i < 400; i++) begin
         rstn  = ($urandom_range(0, 29) != 0);
         reset_addr = {8'($urandom), 30'($urandom), 2'b00};
         stall = ($urandom_range(0, 4) == 0);
         retry = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 5))
            0:       cu.next_pc = NEXT_PC_SEL_KEEP_PC;
            1:       cu.next_pc = NEXT_PC_SEL_JUMP;
            default: cu.next_pc = NEXT_PC_SEL_BP_OR_PC_4;
         endcase
         pc_jump = {8'($urandom), 32'($urandom)};
         if ($urandom_range(0, 3) != 0) pc_jump[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) pc_jump = 40'hFFFFFFFFFC;
         inv_ic  = 1'($urandom);
         inv_buf = 1'($urandom);
         resp.valid = 1'($urandom);
         resp.data  = $urandom;
         resp.instr_access_fault = ($urandom_range(0, 5) == 0);
         resp.instr_page_fault   = ($urandom_range(0, 5) == 0);
         exe = {8'($urandom), 32'($urandom), 8'($urandom), 32'($urandom), 2'($urandom)};
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
